// File: rtl/pipe_frame_pkg.sv
// Shared types and constants for the pipe frame dispatcher.
// Frame layout: {channel, length} header, then `length` payload bytes.
package pipe_frame_pkg;

  typedef enum logic [1:0] {HDR_CH, HDR_LEN, PAYLOAD, DROP} state_e;

  localparam int unsigned HDR_BYTES = 2;
  localparam int unsigned LEN_W     = 8;

endpackage

// File: rtl/pipe_idle_timer.sv
// Idle-cycle counter: counts enabled cycles and pulses expire on the TIMEOUT-th one.
// A TIMEOUT of zero never expires.
module pipe_idle_timer #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign expire = (TIMEOUT != 0) && en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || expire) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_frame_dispatcher.sv
// Parses {channel, length, payload...} frames from the byte pipe and steers payload
// bytes to one of NCH consumers through a single-stage output register.
module pipe_frame_dispatcher
  import pipe_frame_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             pipe_rdy,
  input  logic [7:0]       pipe_data,
  output logic             pipe_en,
  output logic [7:0]       out_data,
  output logic [NCH-1:0]   out_valid,
  output logic             out_last,
  input  logic [NCH-1:0]   out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] ch_q, ch_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             oreg_v_q;
  logic [7:0]       oreg_data_q;
  logic             oreg_last_q;
  logic [CW-1:0]    ch_o_q;
  logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;

  logic bad, load, frame_inc, err_inc, expire, timer_en, timer_clr;

  // Full 8-bit compare, so any nonzero bit above CW also marks the frame bad.
  assign bad = 32'(ch_q) >= NCH;

  // Gated by RST_N so the pipe is never drained while the block is held in reset.
  always_comb begin
    pipe_en = 1'b0;
    if (RST_N) begin
      if (state_q == PAYLOAD) begin
        pipe_en = pipe_rdy & (~oreg_v_q | out_ready[ch_o_q]);
      end else begin
        pipe_en = pipe_rdy;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    rem_d     = rem_q;
    load      = 1'b0;
    frame_inc = 1'b0;
    err_inc   = 1'b0;
    unique case (state_q)
      HDR_CH: begin
        if (pipe_en) begin
          ch_d    = pipe_data;
          state_d = HDR_LEN;
        end
      end
      HDR_LEN: begin
        if (pipe_en) begin
          rem_d = pipe_data;
          if (pipe_data == '0) begin
            err_inc   = bad;
            frame_inc = ~bad;
            state_d   = HDR_CH;
          end else begin
            state_d = bad ? DROP : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (pipe_en) begin
          load  = 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            frame_inc = 1'b1;
            state_d   = HDR_CH;
          end
        end
      end
      DROP: begin
        if (pipe_en) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            err_inc = 1'b1;
            state_d = HDR_CH;
          end
        end
      end
      default: state_d = HDR_CH;
    endcase
    if (expire) begin
      err_inc = 1'b1;
      state_d = HDR_CH;
    end
  end

  assign timer_en  = (state_q != HDR_CH) && !pipe_en;
  assign timer_clr = (state_q == HDR_CH) || pipe_en;

  pipe_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (timer_clr),
    .en    (timer_en),
    .expire(expire)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= HDR_CH;
      ch_q    <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      rem_q   <= rem_d;
    end
  end

  // ch_o is captured with the byte so a following header cannot retarget it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      oreg_v_q    <= 1'b0;
      oreg_data_q <= '0;
      oreg_last_q <= 1'b0;
      ch_o_q      <= '0;
    end else if (load) begin
      oreg_v_q    <= 1'b1;
      oreg_data_q <= pipe_data;
      oreg_last_q <= (rem_q == LEN_W'(1));
      ch_o_q      <= ch_q[CW-1:0];
    end else if (oreg_v_q && out_ready[ch_o_q]) begin
      oreg_v_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (frame_inc && (frame_cnt_q != '1)) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (err_inc && (err_cnt_q != '1))     err_cnt_q   <= err_cnt_q + 1'b1;
    end
  end

  assign out_data  = oreg_data_q;
  assign out_last  = oreg_v_q & oreg_last_q;
  assign out_valid = oreg_v_q ? (NCH'(1) << ch_o_q) : '0;
  assign busy      = (state_q != HDR_CH) || oreg_v_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_pipe_frame_dispatcher.sv
// Bench for pipe_frame_dispatcher: frame-level model compared every cycle, plus
// directed frames with literal expectations.
module tb_pipe_frame_dispatcher;

  localparam int unsigned NCH   = 4;
  localparam int unsigned TO    = 16;
  localparam int unsigned CNT_W = 4;
  localparam int          SAT   = 15;

  logic             CLK;
  logic             RST_N;
  logic             pipe_rdy;
  logic [7:0]       pipe_data;
  logic             pipe_en;
  logic [7:0]       out_data;
  logic [NCH-1:0]   out_valid;
  logic             out_last;
  logic [NCH-1:0]   out_ready;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;

  pipe_frame_dispatcher #(
    .NCH    (NCH),
    .TIMEOUT(TO),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .pipe_rdy (pipe_rdy),
    .pipe_data(pipe_data),
    .pipe_en  (pipe_en),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy),
    .frame_cnt(frame_cnt),
    .err_cnt  (err_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Stimulus state
  logic [7:0]     src[$];
  logic [NCH-1:0] rdy_set;
  bit             starve;
  bit             model_on = 0;

  // Deliveries predicted by the model
  int log_ch[$];
  int log_data[$];
  int log_last[$];
  int log_cyc[$];

  function automatic int get_ch(input int i);
    return (i < log_ch.size()) ? log_ch[i] : -1;
  endfunction
  function automatic int get_data(input int i);
    return (i < log_data.size()) ? log_data[i] : -1;
  endfunction
  function automatic int get_last(input int i);
    return (i < log_last.size()) ? log_last[i] : -1;
  endfunction
  function automatic int get_cyc(input int i);
    return (i < log_cyc.size()) ? log_cyc[i] : -100;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  // Frame-level model: pos 0 = expecting channel, 1 = expecting length, 2 = in body.
  int pos, m_ch, m_rem, idle, m_frames, m_errs, h_ch, cyc;
  bit m_bad, h_v, h_last;
  int h_data;

  always @(negedge CLK) begin
    bit en_x, acc, ld, nl;
    int nd;
    logic [NCH-1:0] exp_v;
    if (!RST_N) begin
      pos = 0; m_ch = 0; m_rem = 0; m_bad = 0; idle = 0;
      m_frames = 0; m_errs = 0; h_v = 0; h_data = 0; h_last = 0; h_ch = 0;
    end
    en_x  = RST_N && pipe_rdy && (pos != 2 || m_bad || !h_v || out_ready[h_ch]);
    exp_v = h_v ? NCH'(1 << h_ch) : '0;
    if (model_on) begin
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      if (h_v) begin
        chk("out_data", 32'(out_data), 32'(h_data));
        chk("out_last", 32'(out_last), 32'(h_last));
      end
      chk("pipe_en", 32'(pipe_en), 32'(en_x));
      chk("busy", 32'(busy), 32'((pos != 0) || h_v));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
      chk("err_cnt", 32'(err_cnt), 32'(m_errs));
    end
    if (RST_N && model_on) begin
      acc = h_v && out_ready[h_ch];
      ld  = 0; nd = 0; nl = 0;
      if (acc) begin
        log_ch.push_back(h_ch); log_data.push_back(h_data);
        log_last.push_back(int'(h_last)); log_cyc.push_back(cyc);
      end
      if (en_x) begin
        idle = 0;
        if (pos == 0) begin
          m_ch = int'(pipe_data);
          pos  = 1;
        end else if (pos == 1) begin
          m_rem = int'(pipe_data);
          m_bad = (m_ch >= NCH);
          if (m_rem == 0) begin
            if (m_bad) m_errs = sat_inc(m_errs); else m_frames = sat_inc(m_frames);
            pos = 0;
          end else begin
            pos = 2;
          end
        end else begin
          if (!m_bad) begin
            ld = 1; nd = int'(pipe_data); nl = (m_rem == 1);
          end
          m_rem--;
          if (m_rem == 0) begin
            if (m_bad) m_errs = sat_inc(m_errs); else m_frames = sat_inc(m_frames);
            pos = 0;
          end
        end
      end else if (pos != 0) begin
        idle++;
        if (idle == TO) begin
          m_errs = sat_inc(m_errs);
          pos    = 0;
          idle   = 0;
        end
      end
      if (ld) begin
        h_v = 1; h_data = nd; h_last = nl; h_ch = m_ch;
      end else if (acc) begin
        h_v = 0;
      end
    end
    cyc++;
  end

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step();
    bit took;
    @(negedge CLK);
    took = pipe_en && pipe_rdy;
    @(posedge CLK);
    #1;
    if (took && src.size() > 0) void'(src.pop_front());
    pipe_rdy  = (src.size() > 0) && !starve;
    pipe_data = (src.size() > 0) ? src[0] : 8'h00;
    out_ready = rdy_set;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic put(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) src.push_back(bytes[8*(n-1-i) +: 8]);
  endtask

  task automatic clear_logs();
    log_ch.delete(); log_data.delete(); log_last.delete(); log_cyc.delete();
  endtask

  task automatic do_reset();
    RST_N     = 1'b0;
    model_on  = 1;
    src.delete();
    pipe_rdy  = 1'b0;
    pipe_data = 8'h00;
    rdy_set   = '1;
    out_ready = '1;
    starve    = 0;
    step();
    step();
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_last", 32'(out_last), 32'h0);
    RST_N = 1'b1;
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    RST_N     = 1'b1;
    pipe_rdy  = 1'b0;
    pipe_data = 8'h00;
    out_ready = '1;
    rdy_set   = '1;
    starve    = 0;
    #1;

    // 1: back-to-back delivery to ch1
    do_reset();
    put(64'h01_03_AA_BB_CC, 5);
    run(12);
    chk("t1_count", log_data.size(), 3);
    chk("t1_d0", get_data(0), 32'hAA);
    chk("t1_d1", get_data(1), 32'hBB);
    chk("t1_d2", get_data(2), 32'hCC);
    chk("t1_ch", get_ch(0) + get_ch(1) + get_ch(2), 3);
    chk("t1_last", {get_last(0) == 0, get_last(1) == 0, get_last(2) == 1}, 3'b111);
    chk("t1_consec", {get_cyc(1) - get_cyc(0) == 1, get_cyc(2) - get_cyc(1) == 1}, 2'b11);
    chk("t1_frame_cnt", 32'(frame_cnt), 1);

    // 2: ch2 stalls with first byte held
    do_reset();
    rdy_set = 4'b1011;
    put(64'h02_02_11_22, 4);
    for (int i = 0; i < 20 && out_valid == '0; i++) step();
    chk("t2_valid_seen", 32'(out_valid), 32'b0100);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_hold_data", 32'(out_data), 32'h11);
      chk("t2_hold_valid", 32'(out_valid), 32'b0100);
      chk("t2_pipe_en", 32'(pipe_en), 0);
    end
    rdy_set = '1;
    run(6);
    chk("t2_count", log_data.size(), 2);
    chk("t2_d0", get_data(0), 32'h11);
    chk("t2_d1", get_data(1), 32'h22);
    chk("t2_ch", {get_ch(0) == 2, get_ch(1) == 2}, 2'b11);
    chk("t2_last", {get_last(0) == 0, get_last(1) == 1}, 2'b11);
    chk("t2_frame_cnt", 32'(frame_cnt), 1);

    // 3: absent channel dropped, next frame delivered
    do_reset();
    put(64'h07_02_55_66_00_01_77, 7);
    run(14);
    chk("t3_count", log_data.size(), 1);
    chk("t3_d0", get_data(0), 32'h77);
    chk("t3_ch", get_ch(0), 0);
    chk("t3_last", get_last(0), 1);
    chk("t3_err_cnt", 32'(err_cnt), 1);
    chk("t3_frame_cnt", 32'(frame_cnt), 1);

    // 4: zero-length frame
    do_reset();
    put(64'h03_00, 2);
    run(5);
    chk("t4_count", log_data.size(), 0);
    chk("t4_frame_cnt", 32'(frame_cnt), 1);
    chk("t4_busy", 32'(busy), 0);

    // 5: starvation timeout, then recovery
    do_reset();
    put(64'h01_04_A0, 3);
    run(16);
    chk("t5_err_early", 32'(err_cnt), 0);
    chk("t5_busy_early", 32'(busy), 1);
    run(6);
    chk("t5_err_cnt", 32'(err_cnt), 1);
    chk("t5_busy", 32'(busy), 0);
    put(64'h01_01_B0, 3);
    run(6);
    chk("t5_count", log_data.size(), 2);
    chk("t5_d0", get_data(0), 32'hA0);
    chk("t5_d1", get_data(1), 32'hB0);
    chk("t5_ch", {get_ch(0) == 1, get_ch(1) == 1}, 2'b11);
    chk("t5_last", {get_last(0) == 0, get_last(1) == 1}, 2'b11);
    chk("t5_frame_cnt", 32'(frame_cnt), 1);

    // 6: asynchronous reset mid-payload
    do_reset();
    rdy_set = '0;
    put(64'h01_00_02_05_01_02_03, 7);
    for (int i = 0; i < 20 && out_valid == '0; i++) step();
    chk("t6_valid_seen", 32'(out_valid), 32'b0100);
    chk("t6_frame_pre", 32'(frame_cnt), 1);
    #1;
    RST_N = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_pipe_en", 32'(pipe_en), 0);
    chk("t6_rst_frame", 32'(frame_cnt), 0);
    chk("t6_rst_err", 32'(err_cnt), 0);
    src.delete();
    pipe_rdy = 1'b0;
    rdy_set  = '1;
    run(2);
    RST_N = 1'b1;
    clear_logs();
    put(64'h01_01_5A, 3);
    run(6);
    chk("t6_count", log_data.size(), 1);
    chk("t6_d0", get_data(0), 32'h5A);
    chk("t6_ch", get_ch(0), 1);
    chk("t6_frame_cnt", 32'(frame_cnt), 1);

    // 7: counter saturation
    do_reset();
    for (int i = 0; i < 17; i++) put(64'h00_00, 2);
    for (int i = 0; i < 17; i++) put(64'h09_00, 2);
    run(80);
    chk("t7_frame_sat", 32'(frame_cnt), SAT);
    chk("t7_err_sat", 32'(err_cnt), SAT);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
